// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide engine:
// funct encodings of the supported HI/LO-producing instructions and decode helpers.
package mult_div_unit_pkg;

  localparam int FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;

  // True for any of the four operations this engine executes.
  function automatic logic is_md_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // True for the divide flavours (signed or unsigned).
  function automatic logic is_div_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  // True for the two's-complement flavours (operands treated as signed).
  function automatic logic is_signed_funct(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring radix-2 division iteration on unsigned magnitudes.
// rem_quo holds {partial remainder, remaining dividend bits / quotient bits}.
// The pair is shifted left by one; the divisor is trial-subtracted from the
// widened partial remainder and the quotient LSB records "no borrow".
module mult_div_unit_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W-1:0] rem_quo,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] rem_quo_next
);

  // The shifted remainder needs one extra bit: 2*rem+1 can exceed DATA_W bits.
  logic [DATA_W:0]   partial;
  logic [DATA_W-1:0] diff_lo;
  logic              borrow;

  assign partial = rem_quo[2*DATA_W-1:DATA_W-1];
  assign borrow  = partial < {1'b0, divisor};
  // When there is no borrow the true difference is below the divisor, so the
  // low DATA_W bits of the modular subtraction are exact.
  assign diff_lo = partial[DATA_W-1:0] - divisor;

  assign rem_quo_next = {(borrow ? partial[DATA_W-1:0] : diff_lo),
                         rem_quo[DATA_W-2:0], ~borrow};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine for the EX stage. Runs MULT/MULTU/DIV/DIVU
// over DATA_W cycles on operand magnitudes, applies the sign fixup when the
// last iteration completes, and presents {HI,LO} with a one-cycle done pulse.
// stall_req holds the front of the pipeline while an operation is in flight.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = {DATA_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  md_en,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     operand_1,
  input  logic [DATA_W-1:0]     operand_2,
  output logic [2*DATA_W-1:0]   mult_div_result,
  output logic                  mult_div_done,
  output logic                  stall_req
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]    count_q;
  logic                sign1_q, sign2_q;
  logic [2*DATA_W-1:0] mcand_q;     // multiplicand, shifted left each cycle
  logic [DATA_W-1:0]   mplier_q;    // multiplier, consumed LSB first
  logic [2*DATA_W-1:0] acc_q;       // product accumulator
  logic [2*DATA_W-1:0] rem_quo_q;   // {remainder, quotient} division pair
  logic [DATA_W-1:0]   divisor_q;
  logic [2*DATA_W-1:0] result_q;

  // Start-cycle decode of the EX instruction.
  logic              start;
  logic              op_signed, op_div, div_zero;
  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] mag1, mag2;

  assign start     = md_en && !flush && is_md_funct(funct);
  assign op_signed = is_signed_funct(funct);
  assign op_div    = is_div_funct(funct);
  assign div_zero  = op_div && (operand_2 == '0);
  assign op1_neg   = op_signed && operand_1[DATA_W-1];
  assign op2_neg   = op_signed && operand_2[DATA_W-1];
  assign mag1      = op1_neg ? -operand_1 : operand_1;
  assign mag2      = op2_neg ? -operand_2 : operand_2;

  // Iteration datapath and sign-fixed final results.
  logic                last_iter;
  logic [2*DATA_W-1:0] acc_next, rem_quo_next;
  logic [2*DATA_W-1:0] mul_fixed, div_fixed;
  logic [DATA_W-1:0]   quo_mag, rem_mag;

  assign last_iter = (count_q == LAST_CNT);
  assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mul_fixed = (sign1_q ^ sign2_q) ? -acc_next : acc_next;
  assign quo_mag   = rem_quo_next[DATA_W-1:0];
  assign rem_mag   = rem_quo_next[2*DATA_W-1:DATA_W];
  assign div_fixed = {(sign1_q ? -rem_mag : rem_mag),
                      ((sign1_q ^ sign2_q) ? -quo_mag : quo_mag)};

  mult_div_unit_div_step #(
    .DATA_W       (DATA_W)
  ) u_div_step (
    .rem_quo      (rem_quo_q),
    .divisor      (divisor_q),
    .rem_quo_next (rem_quo_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode plus done/stall outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    mult_div_done = 1'b0;
    stall_req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          stall_req = 1'b1;
          if (div_zero)    state_d = ST_DONE;
          else if (op_div) state_d = ST_DIV;
          else             state_d = ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        stall_req = 1'b1;
        if (flush)          state_d = ST_IDLE;
        else if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: begin
        mult_div_done = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, per-cycle iteration and result capture.
  always_ff @(posedge clk) begin
    // NOTE: the whole datapath is reset, not just the control, so a reset
    // mid-operation also clears the visible result and iteration counter.
    if (rst) begin
      count_q   <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      rem_quo_q <= '0;
      divisor_q <= '0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            count_q   <= '0;
            sign1_q   <= op1_neg;
            sign2_q   <= op2_neg;
            mcand_q   <= {{DATA_W{1'b0}}, mag1};
            mplier_q  <= mag2;
            acc_q     <= '0;
            rem_quo_q <= {{DATA_W{1'b0}}, mag1};
            divisor_q <= mag2;
            if (div_zero) result_q <= {operand_1, DIV0_LO};
          end
        end
        ST_MUL: begin
          if (!flush) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CNT_W'(1);
            if (last_iter) result_q <= mul_fixed;
          end
        end
        ST_DIV: begin
          if (!flush) begin
            rem_quo_q <= rem_quo_next;
            count_q   <= count_q + CNT_W'(1);
            if (last_iter) result_q <= div_fixed;
          end
        end
        default: ;
      endcase
    end
  end

  assign mult_div_result = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations checked against an arithmetic reference model via a scoreboard.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [FUNCT_W-1:0] funct;
  logic               md_en;
  logic               flush;
  logic [31:0]        operand_1;
  logic [31:0]        operand_2;
  logic [63:0]        mult_div_result;
  logic               mult_div_done;
  logic               stall_req;

  int          n_tests = 0;
  int          n_fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_result = '0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk             (clk),
    .rst             (rst),
    .funct           (funct),
    .md_en           (md_en),
    .flush           (flush),
    .operand_1       (operand_1),
    .operand_2       (operand_2),
    .mult_div_result (mult_div_result),
    .mult_div_done   (mult_div_done),
    .stall_req       (stall_req)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the instruction semantics.
  function automatic logic [63:0] model(input logic [FUNCT_W-1:0] f,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    int          q, r;
    logic [63:0] up;
    if (f == FUNCT_MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    if (f == FUNCT_MULTU) begin
      up = {32'b0, a} * {32'b0, b};
      return up;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (f == FUNCT_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    case ($urandom_range(0, 6))
      0:       r = 32'd0;
      1:       r = 32'h8000_0000;
      2:       r = 32'hFFFF_FFFF;
      3:       r = $urandom_range(0, 20);
      4: begin r = $urandom_range(1, 20); r = -r; end
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding op.
  initial begin
    forever begin
      @(negedge clk);
      if (mult_div_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(mult_div_done), 64'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("result", mult_div_result, e);
          last_result = e;
        end
      end
    end
  end

  // Present an instruction in EX during the next IDLE-cycle half and record its expectation.
  task automatic drive(input logic [FUNCT_W-1:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct     = f;
    operand_1 = a;
    operand_2 = b;
    md_en     = 1'b1;
    exp_q.push_back(model(f, a, b));
  endtask

  // Issue and hold until done; checks stall shape and start-to-done latency.
  task automatic issue(input logic [FUNCT_W-1:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int exp_lat;
    drive(f, a, b);
    exp_lat = (is_div_funct(f) && b == 32'd0) ? 1 : 33;
    #1 check("stall_start", 64'(stall_req), 64'd1);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (mult_div_done === 1'b1) break;
      check("stall_busy", 64'(stall_req), 64'd1);
    end
    check("done_seen", 64'(mult_div_done), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_in_done", 64'(stall_req), 64'd0);
    if (mult_div_done !== 1'b1 && exp_q.size() > 0) void'(exp_q.pop_back());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; md_en = 1'b0; flush = 1'b0; funct = '0;
    operand_1 = '0; operand_2 = '0;
    repeat (3) @(negedge clk);
    check("rst_result", mult_div_result, 64'd0);
    check("rst_done", 64'(mult_div_done), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;

    // Directed corner cases, issued back to back with md_en held across DONE.
    issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", mult_div_result, 64'hFFFF_FFFE_0000_0001);
    issue(FUNCT_MULT, -32'd3, 32'd7);
    check("mult_neg", mult_div_result, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(FUNCT_DIV, -32'd7, 32'd2);
    check("div_neg", mult_div_result, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(FUNCT_DIVU, 32'd100, 32'd0);
    check("divu_zero", mult_div_result, {32'd100, 32'hFFFF_FFFF});
    issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", mult_div_result, {32'd0, 32'h8000_0000});

    // Unsupported funct is not started and raises no stall.
    @(negedge clk);
    funct = 6'b100000; md_en = 1'b1;
    #1 check("bad_funct_stall", 64'(stall_req), 64'd0);
    repeat (3) @(negedge clk);
    check("bad_funct_no_done", 64'(mult_div_done), 64'd0);
    md_en = 1'b0;

    // Flush in the middle of a divide: abort, no done, old result retained.
    drive(FUNCT_DIVU, 32'd12345, 32'd17);
    repeat (10) @(negedge clk);
    flush = 1'b1; md_en = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_stall", 64'(stall_req), 64'd0);
    check("flush_no_done", 64'(mult_div_done), 64'd0);
    check("flush_keep", mult_div_result, last_result);
    repeat (40) @(negedge clk);

    // Flush during DONE still lets the pulse through.
    drive(FUNCT_DIVU, 32'd5, 32'd0);
    @(negedge clk);
    flush = 1'b1; md_en = 1'b0;
    check("flush_in_done", 64'(mult_div_done), 64'd1);
    @(negedge clk);
    flush = 1'b0;

    // Reset in the middle of a multiply clears everything; next op is clean.
    drive(FUNCT_MULT, 32'd123456, -32'd789);
    repeat (5) @(negedge clk);
    rst = 1'b1; md_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    last_result = '0;
    check("midrst_result", mult_div_result, 64'd0);
    check("midrst_done", 64'(mult_div_done), 64'd0);
    check("midrst_stall", 64'(stall_req), 64'd0);
    issue(FUNCT_MULTU, 32'd6, 32'd7);
    check("after_rst_mul", mult_div_result, 64'd42);

    // Randomized operations with occasional idle gaps.
    for (int i = 0; i < 60; i++) begin
      logic [FUNCT_W-1:0] f;
      case ($urandom_range(0, 3))
        0:       f = FUNCT_MULT;
        1:       f = FUNCT_MULTU;
        2:       f = FUNCT_DIV;
        default: f = FUNCT_DIVU;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        md_en = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue(f, rand_operand(), rand_operand());
    end

    @(negedge clk);
    md_en = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
